// File: rtl/fb_clear_engine.sv
// fb_clear_engine: fills a framebuffer region with a latched RGB565 colour
// by issuing back-to-back 64-bit writes to the PSRAM arbiter write port.
module fb_clear_engine #(
    parameter logic [20:0] P_BASE_ADDR = 21'd0,
    parameter int          P_NUM_WORDS = 230400,
    parameter int          P_ADDR_STEP = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_fill_color,
    input  logic        i_init_calib,
    output logic        o_write_req,
    input  logic        i_write_gnt,
    output logic [20:0] o_write_addr,
    output logic [63:0] o_write_data,
    output logic [7:0]  o_write_data_mask,
    output logic        o_busy,
    output logic        o_done
);
    typedef enum logic [1:0] {IDLE, WAIT_CALIB, WRITE, DONE} state_t;

    localparam logic [17:0] LAST_CNT = 18'(P_NUM_WORDS - 1);
    localparam logic [20:0] STEP     = 21'(P_ADDR_STEP);

    state_t      state, state_nxt;
    logic [20:0] addr;
    logic [17:0] cnt;
    logic [15:0] color;
    logic        beat;

    assign beat = (state == WRITE) && i_write_gnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Abort outranks completion of the final beat: no o_done after a cancel.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = i_start ? WAIT_CALIB : IDLE;
            WAIT_CALIB: state_nxt = i_abort ? IDLE : (i_init_calib ? WRITE : WAIT_CALIB);
            WRITE:      state_nxt = i_abort ? IDLE : ((beat && cnt == LAST_CNT) ? DONE : WRITE);
            DONE:       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr  <= P_BASE_ADDR;
            cnt   <= '0;
            color <= '0;
        end else if (state == IDLE && i_start) begin
            addr  <= P_BASE_ADDR;
            cnt   <= '0;
            color <= i_fill_color;
        end else if (beat) begin
            addr  <= addr + STEP;
            cnt   <= cnt + 18'd1;
        end
    end

    assign o_write_req       = (state == WRITE);
    assign o_write_addr      = addr;
    assign o_write_data      = {4{color}};
    assign o_write_data_mask = 8'h00;
    assign o_busy            = (state != IDLE);
    assign o_done            = (state == DONE);
endmodule

// File: tb/tb_fb_clear_engine.sv
// tb_fb_clear_engine: directed and randomised clears checked against a
// beat-count model of the expected address/data sequence.
module tb_fb_clear_engine;
    localparam logic [20:0] BASE = 21'd0;
    localparam int          N    = 8;
    localparam int          STEP = 4;

    logic        i_clk = 0;
    logic        i_rst_n = 0;
    logic        i_start = 0;
    logic        i_abort = 0;
    logic [15:0] i_fill_color = 0;
    logic        i_init_calib = 0;
    logic        i_write_gnt = 0;
    logic        o_write_req;
    logic [20:0] o_write_addr;
    logic [63:0] o_write_data;
    logic [7:0]  o_write_data_mask;
    logic        o_busy;
    logic        o_done;

    int n_assert = 0;
    int n_fail   = 0;

    fb_clear_engine #(.P_BASE_ADDR(BASE), .P_NUM_WORDS(N), .P_ADDR_STEP(STEP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_fill_color(i_fill_color), .i_init_calib(i_init_calib),
        .o_write_req(o_write_req), .i_write_gnt(i_write_gnt),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data),
        .o_write_data_mask(o_write_data_mask), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, 64'(o_write_req), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    // One clear: calib_delay cycles with calib low, optional abort when the
    // model has seen abort_at beats, optional second start mid-clear.
    task automatic run_clear(input logic [15:0] col, input int calib_delay,
                             input int abort_at, input bit second_start);
        logic [63:0] exp_data;
        int beats, gap;
        bit fin, aborted;
        exp_data = {4{col}};
        beats = 0; fin = 0; aborted = 0;
        i_init_calib = (calib_delay == 0);
        i_fill_color = col;
        i_start = 1;
        step();
        i_start = 0;
        i_fill_color = 16'($urandom);
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_req", 64'(o_write_req), 64'd0);
        i_write_gnt = 1;
        for (int c = 0; c < calib_delay; c++) begin
            step();
            chk("calib_req", 64'(o_write_req), 64'd0);
            chk("calib_busy", 64'(o_busy), 64'd1);
        end
        i_init_calib = 1;
        i_write_gnt = 0;
        step();
        gap = $urandom_range(0, 10);
        for (int c = 0; c < 400 && !fin; c++) begin
            chk("wr_req", 64'(o_write_req), 64'd1);
            chk("wr_addr", 64'(o_write_addr), 64'(21'(BASE + beats * STEP)));
            chk("wr_data", o_write_data, exp_data);
            chk("wr_mask", 64'(o_write_data_mask), 64'h00);
            chk("wr_done", 64'(o_done), 64'd0);
            if (second_start && beats == 2) begin
                i_start = 1;
                i_fill_color = 16'h07E0;
            end
            if (beats == abort_at) i_abort = 1;
            i_write_gnt = (gap == 0);
            if (i_write_gnt) begin
                beats++;
                gap = $urandom_range(0, 10);
            end else gap--;
            step();
            i_start = 0;
            i_write_gnt = 0;
            if (i_abort) begin
                i_abort = 0;
                aborted = 1;
                fin = 1;
            end else if (beats == N) fin = 1;
        end
        chk("finished", 64'(fin), 64'd1);
        if (aborted) begin
            chk_idle("abort");
            step();
            chk_idle("abort_after");
        end else begin
            chk("end_req", 64'(o_write_req), 64'd0);
            chk("end_done", 64'(o_done), 64'd1);
            chk("end_busy", 64'(o_busy), 64'd1);
            step();
            chk_idle("end_after");
        end
    endtask

    initial begin
        #2;
        chk_idle("reset");
        chk("reset_addr", 64'(o_write_addr), 64'(BASE));
        chk("reset_data", o_write_data, 64'd0);
        chk("reset_mask", 64'(o_write_data_mask), 64'h00);
        step();
        i_rst_n = 1;
        step();
        i_abort = 1;
        step();
        i_abort = 0;
        chk_idle("abort_idle");

        run_clear(16'hF800, 0, -1, 0);
        run_clear(16'h1234, 50, -1, 0);
        run_clear(16'hABCD, 0, 3, 0);
        run_clear(16'h001F, 0, -1, 0);
        run_clear(16'hF800, 3, -1, 1);

        // Start and abort together in IDLE: start must win.
        i_abort = 1;
        i_init_calib = 1;
        i_start = 1;
        i_fill_color = 16'h5555;
        step();
        i_start = 0;
        i_abort = 0;
        chk("start_wins_busy", 64'(o_busy), 64'd1);
        step();
        chk("start_wins_req", 64'(o_write_req), 64'd1);
        chk("start_wins_data", o_write_data, {4{16'h5555}});
        i_write_gnt = 1;
        step();
        step();
        i_write_gnt = 0;
        chk("pre_rst_addr", 64'(o_write_addr), 64'(21'(BASE + 2 * STEP)));
        #2;
        i_rst_n = 0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_addr", 64'(o_write_addr), 64'(BASE));
        chk("async_rst_data", o_write_data, 64'd0);
        step();
        i_rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_idle("post_rst");
        end

        for (int k = 0; k < 4; k++)
            run_clear(16'($urandom), $urandom_range(0, 5), (k == 2) ? 5 : -1, k[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_clear_engine.md
FB_CLEAR_ENGINE -- requirements
Module: fb_clear_engine

Interface
REQ-001 The block SHALL have parameter P_BASE_ADDR, default 21'd0, first framebuffer word address.
REQ-002 The block SHALL have parameter P_NUM_WORDS, default 230400, 64-bit writes per clear (1280x720 RGB565).
REQ-003 The block SHALL have parameter P_ADDR_STEP, default 4, address increment per 64-bit write.
REQ-004 The block SHALL have port i_clk, input, 1, PSRAM user clock; all logic in this single domain.
REQ-005 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port i_start, input, 1, one-cycle clear request (from inst_dec_reg clear request).
REQ-007 The block SHALL have port i_abort, input, 1, cancel clear in progress.
REQ-008 The block SHALL have port i_fill_color, input, 16, RGB565 fill value.
REQ-009 The block SHALL have port i_init_calib, input, 1, PSRAM calibration complete.
REQ-010 The block SHALL have port o_write_req, output, 1, write request to psram_arb write port.
REQ-011 The block SHALL have port i_write_gnt, input, 1, one-cycle grant from arbiter.
REQ-012 The block SHALL have port o_write_addr, output, 21, write word address.
REQ-013 The block SHALL have port o_write_data, output, 64, write data.
REQ-014 The block SHALL have port o_write_data_mask, output, 8, byte mask (1 = masked).
REQ-015 The block SHALL have port o_busy, output, 1, clear in progress or pending.
REQ-016 The block SHALL have port o_done, output, 1, one-cycle pulse on clear completion.

Function
REQ-017 The block SHALL implement states IDLE, WAIT_CALIB, WRITE, DONE.
REQ-018 IDLE: i_start=1 SHALL latch i_fill_color, load address P_BASE_ADDR, clear word counter, go to WAIT_CALIB.
REQ-019 WAIT_CALIB SHALL go to WRITE on the first cycle i_init_calib=1; it SHALL hold indefinitely while i_init_calib=0.
REQ-020 WRITE SHALL assert o_write_req=1 continuously, with address/data stable until the cycle where o_write_req=1 and i_write_gnt=1 (a beat).
REQ-021 On each beat the block SHALL, next cycle, add P_ADDR_STEP to o_write_addr (21-bit modulo) and increment the 18-bit word counter.
REQ-022 The beat with counter = P_NUM_WORDS-1 SHALL deassert o_write_req next cycle and enter DONE; exactly P_NUM_WORDS beats SHALL occur per clear.
REQ-023 DONE SHALL assert o_done=1 for exactly one cycle, then return to IDLE.
REQ-024 o_write_data SHALL be {4{latched fill color}}; o_write_data_mask SHALL be 8'h00 throughout.
REQ-025 o_busy SHALL be 1 in WAIT_CALIB, WRITE, DONE; 0 in IDLE.
REQ-026 i_start while not in IDLE SHALL be ignored; latched color SHALL NOT change mid-clear.
REQ-027 i_abort=1 in WAIT_CALIB or WRITE SHALL go to IDLE next cycle with o_write_req=0, no o_done; a beat coinciding with abort SHALL count as issued but no further req.
REQ-028 i_abort and i_start both high in IDLE: start SHALL win.
REQ-029 i_write_gnt outside WRITE SHALL be ignored.
REQ-030 Latency: i_start (calib already 1) to first o_write_req=1 SHALL be 2 cycles.

Reset
REQ-031 i_rst_n=0 SHALL asynchronously force IDLE, o_write_req=0, o_write_addr=P_BASE_ADDR, o_write_data=0, o_write_data_mask=8'h00, o_busy=0, o_done=0, counter=0.
REQ-032 Reset mid-clear SHALL abandon the clear; no o_done after release; release SHALL require a new i_start.

Verification
REQ-033 Defaults, calib=1, color 16'hF800, gnt every cycle -> 230400 beats, addr 0..921596 step 4, data 64'hF800F800F800F800, o_done 1 cycle after last beat.
REQ-034 P_NUM_WORDS=8, calib held 0 for 50 cycles after start -> no req, o_busy=1; req 1 cycle after calib rises; 8 beats.
REQ-035 P_NUM_WORDS=8, random gnt gaps 0-10 cycles -> addr/data stable while req&&!gnt; beats exactly 8, addresses 0,4..28.
REQ-036 Abort after 3 beats -> req low next cycle, o_busy=0, no o_done; subsequent start with 16'h001F restarts at P_BASE_ADDR.
REQ-037 Second i_start with 16'h07E0 during clear -> ignored, data stays first color, single o_done.
REQ-038 i_rst_n low mid-WRITE -> all outputs at reset values same cycle; no o_done after release.
